// File: rtl/mouse_force_pipeline_pkg.sv
// Shared mode encodings and fixed-point helpers for the mouse force pipeline.
package mouse_pkg;

    localparam int          FRAC_BITS    = 12;
    localparam logic [31:0] ONE          = 32'h0000_1000;
    localparam logic [31:0] PUSH_DEFAULT = 32'h0000_a000;

    // 2'b11 is deliberately left unnamed: it behaves exactly like MODE_OFF.
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_REPEL   = 2'b01,
        MODE_ATTRACT = 2'b10
    } mode_e;

    function automatic logic [31:0] fx_to_int(input logic [31:0] v);
        return v >> FRAC_BITS;
    endfunction

endpackage

// File: rtl/mouse_force_pipeline_axis_force.sv
// One axis of the force stage: repel/attract displacement and clamp to [0, bound].
// Purely combinational; the caller registers the result.
module axis_force
    import mouse_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic             near_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] push_i,
    input  logic [WIDTH-1:0] bound_i,
    output logic [WIDTH-1:0] q_o
);

    logic               d_neg;
    logic               d_zero;
    logic               active;
    logic [WIDTH-1:0]   d_mag;
    logic [WIDTH-1:0]   m;
    logic signed [WIDTH:0] p_ext;
    logic signed [WIDTH:0] push_ext;
    logic signed [WIDTH:0] m_ext;
    logic signed [WIDTH:0] bound_ext;
    logic signed [WIDTH:0] sum;

    always_comb begin
        d_neg     = d_i[WIDTH-1];
        d_zero    = (d_i == '0);
        d_mag     = d_neg ? -d_i : d_i;
        // d was formed as mouse - p, so p + d recovers the mouse coordinate exactly.
        m         = p_i + d_i;
        p_ext     = {p_i[WIDTH-1], p_i};
        push_ext  = {1'b0, push_i};
        m_ext     = {m[WIDTH-1], m};
        bound_ext = {1'b0, bound_i};
        active    = near_i && (mode_i == MODE_REPEL || mode_i == MODE_ATTRACT);

        sum = p_ext;
        if (mode_i == MODE_REPEL) begin
            sum = d_neg ? p_ext + push_ext : p_ext - push_ext;
        end else if (d_mag < push_i) begin
            sum = m_ext;
        end else if (!d_neg && !d_zero) begin
            sum = p_ext + push_ext;
        end else if (d_neg) begin
            sum = p_ext - push_ext;
        end

        q_o = p_i;
        if (active) begin
            if (sum[WIDTH]) begin
                q_o = '0;
            end else if (sum > bound_ext) begin
                q_o = bound_i;
            end else begin
                q_o = sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mouse_force_pipeline.sv
// Streams particles through a 3-stage mouse repel/attract + clamp pipeline, 1 per cycle, latency 3.
// One global stall: every stage freezes while the output is valid and not accepted.
module mouse_force_pipeline
    import mouse_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               FRAC   = FRAC_BITS,
    parameter int               RADIUS = 20,
    parameter logic [WIDTH-1:0] PUSH   = WIDTH'(PUSH_DEFAULT),
    parameter int               X_MAX  = 640,
    parameter int               Y_MAX  = 480,
    parameter int               ID_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [WIDTH-1:0] mouse_x,
    input  logic [WIDTH-1:0] mouse_y,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [ID_W-1:0]  in_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [ID_W-1:0]  out_id,
    output logic             out_hit,
    output logic [ID_W:0]    hit_count
);

    localparam logic [WIDTH-1:0] X_BOUND  = WIDTH'(X_MAX) << FRAC;
    localparam logic [WIDTH-1:0] Y_BOUND  = WIDTH'(Y_MAX) << FRAC;
    localparam logic [WIDTH-1:0] RADIUS_W = WIDTH'(RADIUS);

    logic [WIDTH-1:0] mx_q, my_q;
    logic [1:0]       mode_q;

    logic             s1_vld_q, s2_vld_q, out_vld_q;
    logic [WIDTH-1:0] s1_x_q, s1_y_q, s1_dx_q, s1_dy_q;
    logic [ID_W-1:0]  s1_id_q;
    logic [1:0]       s1_mode_q;
    logic [WIDTH-1:0] s2_x_q, s2_y_q, s2_dx_q, s2_dy_q;
    logic [ID_W-1:0]  s2_id_q;
    logic [1:0]       s2_mode_q;
    logic             s2_near_q;
    logic [WIDTH-1:0] out_x_q, out_y_q;
    logic [ID_W-1:0]  out_id_q;
    logic             out_hit_q;
    logic [ID_W:0]    hit_count_q, hit_count_d;

    logic             advance, hit_hs, near_d, hit_d;
    logic [WIDTH-1:0] dx_mag, dy_mag, x_d, y_d;

    assign advance   = !out_vld_q || out_ready;
    assign in_ready  = advance;
    assign hit_hs    = out_vld_q && out_ready && out_hit_q;

    // Magnitudes are unsigned so the most negative difference counts as far.
    always_comb begin
        dx_mag = s1_dx_q[WIDTH-1] ? -s1_dx_q : s1_dx_q;
        dy_mag = s1_dy_q[WIDTH-1] ? -s1_dy_q : s1_dy_q;
        near_d = ((dx_mag >> FRAC) < RADIUS_W) && ((dy_mag >> FRAC) < RADIUS_W);
        hit_d  = s2_near_q && (s2_mode_q == MODE_REPEL || s2_mode_q == MODE_ATTRACT);
    end

    always_comb begin
        hit_count_d = hit_count_q;
        if (frame_start) begin
            hit_count_d = {{ID_W{1'b0}}, hit_hs};
        end else if (hit_hs && !(&hit_count_q)) begin
            hit_count_d = hit_count_q + (ID_W+1)'(1);
        end
    end

    axis_force #(.WIDTH(WIDTH)) u_axis_x (
        .d_i(s2_dx_q), .p_i(s2_x_q), .near_i(s2_near_q), .mode_i(s2_mode_q),
        .push_i(PUSH), .bound_i(X_BOUND), .q_o(x_d)
    );

    axis_force #(.WIDTH(WIDTH)) u_axis_y (
        .d_i(s2_dy_q), .p_i(s2_y_q), .near_i(s2_near_q), .mode_i(s2_mode_q),
        .push_i(PUSH), .bound_i(Y_BOUND), .q_o(y_d)
    );

    // Mouse/mode latch is independent of the stall so a frame edge is never missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx_q        <= '0;
            my_q        <= '0;
            mode_q      <= MODE_OFF;
            hit_count_q <= '0;
        end else begin
            hit_count_q <= hit_count_d;
            if (frame_start) begin
                mx_q   <= mouse_x;
                my_q   <= mouse_y;
                mode_q <= mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_dx_q   <= '0;
            s1_dy_q   <= '0;
            s1_id_q   <= '0;
            s1_mode_q <= MODE_OFF;
            s2_vld_q  <= 1'b0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
            s2_dx_q   <= '0;
            s2_dy_q   <= '0;
            s2_id_q   <= '0;
            s2_mode_q <= MODE_OFF;
            s2_near_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_id_q  <= '0;
            out_hit_q <= 1'b0;
        end else if (advance) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                s1_x_q    <= in_x;
                s1_y_q    <= in_y;
                s1_dx_q   <= mx_q - in_x;
                s1_dy_q   <= my_q - in_y;
                s1_id_q   <= in_id;
                s1_mode_q <= mode_q;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_x_q    <= s1_x_q;
                s2_y_q    <= s1_y_q;
                s2_dx_q   <= s1_dx_q;
                s2_dy_q   <= s1_dy_q;
                s2_id_q   <= s1_id_q;
                s2_mode_q <= s1_mode_q;
                s2_near_q <= near_d;
            end
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_x_q   <= x_d;
                out_y_q   <= y_d;
                out_id_q  <= s2_id_q;
                out_hit_q <= hit_d;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_id    = out_id_q;
    assign out_hit   = out_hit_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_mouse_force_pipeline.sv
// Scoreboard bench for mouse_force_pipeline: expected results are queued at input handshake.
module tb_mouse_force_pipeline;

    localparam longint PUSH_L   = 40960;
    localparam longint NEAR_LIM = 20 * 4096;
    localparam longint XB       = 640 * 4096;
    localparam longint YB       = 480 * 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] mouse_x = '0, mouse_y = '0;
    logic [1:0]  mode = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0, in_y = '0;
    logic [9:0]  in_id = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_x, out_y;
    logic [9:0]  out_id;
    logic        out_hit;
    logic [10:0] hit_count;

    mouse_force_pipeline dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_id(out_id), .out_hit(out_hit), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [9:0]  id;
        logic        hit;
    } res_t;

    res_t        sb[$];
    logic [31:0] lmx = '0, lmy = '0;
    logic [1:0]  lmode = 2'b00;
    int          checks = 0, errors = 0;
    bit          acc, hs, ovld, ir;
    res_t        o, last;

    function automatic logic [31:0] fx(input int i);
        return 32'(i * 4096);
    endfunction

    function automatic logic [31:0] ax_model(input logic [31:0] p, input logic [31:0] m,
                                             input logic [1:0] md, input longint bound);
        longint      pl, ml, d, r;
        logic [31:0] dw;
        pl = longint'($signed(p));
        ml = longint'($signed(m));
        dw = m - p;
        d  = longint'($signed(dw));
        if (md == 2'b01) r = (d < 0) ? pl + PUSH_L : pl - PUSH_L;
        else if (d < PUSH_L && d > -PUSH_L) r = ml;
        else if (d > 0) r = pl + PUSH_L;
        else r = pl - PUSH_L;
        if (r < 0) r = 0;
        if (r > bound) r = bound;
        return r[31:0];
    endfunction

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [9:0] id);
        res_t        r;
        logic [31:0] t;
        longint      dx, dy;
        bit          near, act;
        t    = lmx - x;
        dx   = longint'($signed(t));
        t    = lmy - y;
        dy   = longint'($signed(t));
        near = (dx < NEAR_LIM) && (dx > -NEAR_LIM) && (dy < NEAR_LIM) && (dy > -NEAR_LIM);
        act  = (lmode == 2'b01) || (lmode == 2'b10);
        r.id = id;
        if (near && act) begin
            r.x   = ax_model(x, lmx, lmode, XB);
            r.y   = ax_model(y, lmy, lmode, YB);
            r.hit = 1'b1;
        end else begin
            r.x   = x;
            r.y   = y;
            r.hit = 1'b0;
        end
        return r;
    endfunction

    // Called just after a negedge; returns just after the following negedge.
    task automatic step(input bit v, input logic [31:0] x, input logic [31:0] y,
                        input logic [9:0] id, input bit fs, input bit rdy);
        in_valid = v; in_x = x; in_y = y; in_id = id; frame_start = fs; out_ready = rdy;
        #1;
        acc  = v && in_ready;
        if (acc) sb.push_back(model(x, y, id));
        ovld = out_valid;
        ir   = in_ready;
        hs   = out_valid && out_ready;
        o    = '{x: out_x, y: out_y, id: out_id, hit: out_hit};
        @(posedge clk);
        if (fs) begin lmx = mouse_x; lmy = mouse_y; lmode = mode; end
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_x, out_y, out_id, out_hit} !== 75'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", {out_x, out_y, out_id, out_hit}); end
        checks++; if (hit_count !== 11'd0) begin errors++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_repel();
        mouse_x = fx(105); mouse_y = fx(100); mode = 2'b01;
        step(0, 0, 0, 0, 1, 1);
        step(1, fx(100), fx(100), 10'd1, 0, 1);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step(0, 0, 0, 0, 0, 1);
            if (hs) begin
                checks++; last = o;
                if (sb.size() == 0) begin errors++; $display("FAIL repel_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL repel_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL repel_timeout pending=%0d exp=0", sb.size()); end
        checks++; if (last !== {32'h0005A000, 32'h0005A000, 10'd1, 1'b1}) begin errors++; $display("FAIL repel_const got=%h exp=5a000/5a000 hit", last); end
        checks++; if (hit_count !== 11'd1) begin errors++; $display("FAIL repel_hit_count got=%0d exp=1", hit_count); end
        step(1, fx(110), fx(100), 10'd2, 0, 1);
        step(1, fx(100), fx(97), 10'd3, 0, 1);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step(0, 0, 0, 0, 0, 1);
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL repel2_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL repel2_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (hit_count !== 11'd3) begin errors++; $display("FAIL repel2_hit_count got=%0d exp=3", hit_count); end
    endtask

    task automatic test_far_off();
        logic [31:0] tmx[4], tpx[4];
        logic [1:0]  tmd[4];
        tmx = '{fx(130), fx(105), fx(105), fx(105)};
        tmd = '{2'b01, 2'b00, 2'b11, 2'b01};
        tpx = '{fx(100), fx(100), fx(100), 32'h80069000};
        for (int t = 0; t < 4; t++) begin
            mouse_x = tmx[t]; mouse_y = fx(100); mode = tmd[t];
            step(0, 0, 0, 0, 1, 1);
            step(1, tpx[t], fx(100), 10'(20 + t), 0, 1);
            hs = 0;
            for (int c = 0; c < 10 && sb.size() > 0; c++) begin
                step(0, 0, 0, 0, 0, 1);
                if (hs) begin
                    checks++; last = o;
                    if (sb.size() == 0) begin errors++; $display("FAIL faroff_unexpected got=%h", o); end
                    else begin
                        if (o !== sb[0]) begin errors++; $display("FAIL faroff_out case=%0d got=%h exp=%h", t, o, sb[0]); end
                        sb.delete(0);
                    end
                end
            end
            checks++;
            if (last !== {tpx[t], fx(100), 10'(20 + t), 1'b0}) begin
                errors++; $display("FAIL faroff_passthrough case=%0d got=%h exp x=%h hit=0", t, last, tpx[t]);
            end
        end
    endtask

    task automatic test_clamp_attract();
        logic [31:0] tmx[5], tmy[5], tpx[5], tpy[5], ex[5], ey[5];
        logic [1:0]  tmd[5];
        tmx = '{fx(8),   fx(105), fx(115), fx(636), fx(700)};
        tmy = '{fx(100), fx(100), fx(100), fx(475), fx(100)};
        tmd = '{2'b01,   2'b10,   2'b10,   2'b01,   2'b10};
        tpx = '{fx(4),   fx(100), fx(100), fx(638), fx(695)};
        tpy = '{fx(100), fx(100), fx(100), fx(478), fx(100)};
        ex  = '{32'h0, 32'h69000, 32'h6E000, 32'h280000, 32'h280000};
        ey  = '{32'h5A000, 32'h64000, 32'h64000, 32'h1E0000, 32'h64000};
        for (int t = 0; t < 5; t++) begin
            mouse_x = tmx[t]; mouse_y = tmy[t]; mode = tmd[t];
            step(0, 0, 0, 0, 1, 1);
            step(1, tpx[t], tpy[t], 10'(40 + t), 0, 1);
            for (int c = 0; c < 10 && sb.size() > 0; c++) begin
                step(0, 0, 0, 0, 0, 1);
                if (hs) begin
                    checks++; last = o;
                    if (sb.size() == 0) begin errors++; $display("FAIL clamp_unexpected got=%h", o); end
                    else begin
                        if (o !== sb[0]) begin errors++; $display("FAIL clamp_out case=%0d got=%h exp=%h", t, o, sb[0]); end
                        sb.delete(0);
                    end
                end
            end
            checks++;
            if (last !== {ex[t], ey[t], 10'(40 + t), 1'b1}) begin
                errors++; $display("FAIL clamp_const case=%0d got=%h exp x=%h y=%h", t, last, ex[t], ey[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0, got = 0;
        bit   rdy, have_held = 0;
        res_t held = '0;
        mouse_x = fx(105); mouse_y = fx(100); mode = 2'b01;
        step(0, 0, 0, 0, 1, 1);
        for (int s = 0; s < 60 && (sent < 8 || sb.size() > 0); s++) begin
            rdy = !(s >= 4 && s <= 8);
            if (sent < 8) step(1, fx(100 + sent), fx(100), 10'(sent), 0, rdy);
            else step(0, 0, 0, 0, 0, rdy);
            if (acc) sent++;
            if (ovld && !rdy) begin
                checks++; if (ir !== 1'b0) begin errors++; $display("FAIL b2b_in_ready step=%0d got=%b exp=0", s, ir); end
                if (!have_held) begin held = o; have_held = 1; end
                else begin
                    checks++; if (o !== held) begin errors++; $display("FAIL b2b_hold step=%0d got=%h exp=%h", s, o, held); end
                end
            end
            if (hs) begin
                checks++; got++;
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL b2b_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
        checks++; if (!have_held) begin errors++; $display("FAIL b2b_stall_seen got=0 exp=1"); end
    endtask

    task automatic test_frame_latch();
        mouse_x = fx(105); mouse_y = fx(100); mode = 2'b01;
        step(0, 0, 0, 0, 1, 1);
        step(1, fx(100), fx(100), 10'd60, 0, 1);
        mouse_x = fx(130);
        step(1, fx(100), fx(100), 10'd61, 0, 1);
        step(1, fx(100), fx(100), 10'd62, 0, 1);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step(0, 0, 0, 0, 0, 1);
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL latch_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL latch_out got=%h exp=%h", o, sb[0]); end
                    if (o.hit !== 1'b1) begin errors++; $display("FAIL latch_hit got=%b exp=1", o.hit); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (hit_count !== 11'd3) begin errors++; $display("FAIL latch_three_hits got=%0d exp=3", hit_count); end
        for (int s = 0; s < 12; s++) begin
            if (s == 0) step(1, fx(100), fx(100), 10'd63, 0, 1);
            else if (s == 3) step(1, fx(100), fx(100), 10'd64, 1, 1);
            else if (s == 4) step(1, fx(100), fx(100), 10'd65, 0, 1);
            else step(0, 0, 0, 0, 0, 1);
            if (s == 3) begin
                checks++; if (hs !== 1'b1) begin errors++; $display("FAIL latch_frame_hs got=%b exp=1", hs); end
                checks++; if (hit_count !== 11'd1) begin errors++; $display("FAIL latch_frame_count got=%0d exp=1", hit_count); end
            end
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL latch2_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL latch2_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL latch_timeout pending=%0d exp=0", sb.size()); end
        checks++; if (hit_count !== 11'd2) begin errors++; $display("FAIL latch_final_count got=%0d exp=2", hit_count); end
    endtask

    task automatic test_saturation();
        mouse_x = fx(105); mouse_y = fx(100); mode = 2'b01;
        step(0, 0, 0, 0, 1, 1);
        for (int s = 0; s < 2070; s++) begin
            if (s < 2050) step(1, fx(100), fx(100), 10'(s), 0, 1);
            else step(0, 0, 0, 0, 0, 1);
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL sat_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL sat_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sat_timeout pending=%0d exp=0", sb.size()); end
        checks++; if (hit_count !== 11'h7FF) begin errors++; $display("FAIL sat_hit_count got=%0d exp=2047", hit_count); end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        mouse_x = fx(105); mouse_y = fx(100); mode = 2'b01;
        step(0, 0, 0, 0, 1, 1);
        step(1, fx(100), fx(100), 10'd80, 0, 1);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step(0, 0, 0, 0, 0, 1);
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rmid_unexpected got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL rmid_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (hit_count !== 11'd1) begin errors++; $display("FAIL rmid_pre_count got=%0d exp=1", hit_count); end
        step(1, fx(100), fx(100), 10'd81, 0, 1);
        step(1, fx(100), fx(100), 10'd82, 0, 1);
        step(1, fx(100), fx(100), 10'd83, 0, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (hit_count !== 11'd0) begin errors++; $display("FAIL rmid_hit_count got=%0d exp=0", hit_count); end
        sb.delete();
        lmx = '0; lmy = '0; lmode = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, fx(100), fx(100), 10'd90, 0, 1);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rmid_accept got=%b exp=1", acc); end
        for (int c = 1; c <= 10; c++) begin
            step(0, 0, 0, 0, 0, 1);
            if (hs) begin
                checks++;
                if (lat == 0) lat = c;
                if (sb.size() == 0) begin errors++; $display("FAIL rmid_stale got=%h", o); end
                else begin
                    if (o !== sb[0]) begin errors++; $display("FAIL rmid_new_out got=%h exp=%h", o, sb[0]); end
                    sb.delete(0);
                end
            end
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL rmid_latency got=%0d exp=3", lat); end
    endtask

    initial begin
        test_reset();
        test_repel();
        test_far_off();
        test_clamp_attract();
        test_back_to_back();
        test_frame_latch();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_force_pipeline.md
Name: mouse_force_pipeline

Overview:
- Streaming, parametrised successor to the per-particle mouse distance check.
- Accepts one particle position per cycle over a valid/ready handshake and tests it against a mouse box latched once per frame.
- Applies a repel or attract displacement on both axes, clamps the result to screen bounds, and counts affected particles per frame.
- Sits between the particle position RAM reader and the writeback/renderer path.

Parameters:
- WIDTH, 32: fixed-point word width; signed two's complement.
- FRAC, 12: fractional bits; 1.0 = 1<<FRAC.
- RADIUS, 20: box half-size in integer units.
- PUSH, 32'h0000a000: displacement per frame (10.0).
- X_MAX, 640: right clamp bound in integer units.
- Y_MAX, 480: bottom clamp bound in integer units.
- ID_W, 10: particle tag width; hit counter is ID_W+1 bits.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- frame_start, in, 1: one-cycle pulse; latches mouse/mode and clears hit_count.
- mouse_x, in, WIDTH: mouse x position.
- mouse_y, in, WIDTH: mouse y position.
- mode, in, 2: 00 off, 01 repel, 10 attract, 11 off.
- in_valid, in, 1: input particle valid.
- in_ready, out, 1: pipeline accepts input this cycle.
- in_x, in, WIDTH: particle x.
- in_y, in, WIDTH: particle y.
- in_id, in, ID_W: particle tag.
- out_valid, out, 1: output valid.
- out_ready, in, 1: downstream accepts output.
- out_x, out, WIDTH: updated x.
- out_y, out, WIDTH: updated y.
- out_id, out, ID_W: tag, passed through unchanged.
- out_hit, out, 1: particle was inside the box and mode was active.
- hit_count, out, ID_W+1: hits delivered since the last frame_start.

Behaviour:
- Reset (async, rst_n=0): all stage valids 0; out_x/out_y/out_id/out_hit 0; latched mouse 0; latched mode off; hit_count 0. in_ready is 1 one cycle after rst_n deasserts.
- Latching: frame_start samples mouse_x, mouse_y and mode into registers. Particles accepted in the same cycle use the old values; particles accepted from the next cycle on use the new values.
- Pipeline: 3 stages with a global stall. advance = !out_valid || out_ready; in_ready = advance.
  - S1: dx = mx - x, dy = my - y, computed modulo 2^WIDTH.
  - S2: |dx|, |dy| as unsigned magnitudes. near = (|dx|>>FRAC) < RADIUS && (|dy|>>FRAC) < RADIUS. 0x80000000 has magnitude 2^31 and is therefore far.
  - S3: apply displacement and clamp; register outputs.
- Latency: exactly 3 cycles from input handshake to out_valid when out_ready is held 1. Throughput is 1 per cycle. Bubbles are not compacted. Order is preserved; no drop or duplication under any out_ready pattern.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Displacement, applied per axis independently, only when near and mode is 01 or 10:
  - Repel: d<0 gives p+PUSH; d>=0 gives p-PUSH.
  - Attract: |d|<PUSH gives the mouse coordinate exactly; otherwise p+PUSH if d>0, p-PUSH if d<0.
  - Mode 00/11, or not near: p passes through unchanged and out_hit=0.
- Clamp: arithmetic is done in WIDTH+1 bits. Result is limited to [0, X_MAX<<FRAC] for x and [0, Y_MAX<<FRAC] for y. Inputs already out of bounds are also clamped when displaced; unaffected particles are not clamped.
- hit_count: increments on each output handshake (out_valid && out_ready && out_hit). It saturates at all-ones.
- frame_start concurrent with a hit handshake: hit_count becomes 1.

Decomposition:
- Shared package mouse_pkg holds:
  - mode encodings MODE_OFF, MODE_REPEL, MODE_ATTRACT;
  - FRAC_BITS;
  - fixed-point constants ONE and PUSH_DEFAULT;
  - function fx_to_int (>>FRAC).
- One sub-module: axis_force. It is combinational per axis and is instantiated twice, for x and y.
  - Inputs: d, p, near, mode, PUSH, bound.
  - Outputs: displaced and clamped coordinate.
  - The S3 registers live in the top level.

Test Plan:
- Repel near: mode=01, mouse=(105.0, 100.0) i.e. (0x69000, 0x64000), particle (0x64000, 0x64000) -> after 3 cycles out=(0x5A000, 0x5A000), out_hit=1, hit_count=1.
- Far/off: mouse x=130.0 (dx=30) -> out equals input, out_hit=0. Same particle near but mode=00 -> passthrough, out_hit=0.
- Clamp and attract:
  - Repel with particle x=0x4000 (4.0), mouse x=0x8000 -> out_x=0.
  - Attract with particle x=100.0, mouse x=105.0 -> out_x=0x69000; with mouse x=115.0 -> out_x=0x6E000.
- Backpressure: stream ids 0..7 back to back with out_ready=0 for cycles 4-8 -> in_ready=0 while stalled, outputs held stable, ids emerge 0..7 in order exactly once.
- Frame latch: change mouse_x mid-stream without frame_start -> results unchanged. Pulse frame_start together with a hit handshake after 3 prior hits -> hit_count=1; the new mouse applies from the next accepted particle.
- Reset mid-stream: assert rst_n=0 with 3 particles in flight -> out_valid=0 and hit_count=0 immediately. After release no stale particle emerges, and the first new input appears 3 cycles after acceptance.
